pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Fetch-stage program counter controller. It sits directly downstream of the branch decision logic and consumes its jump output plus the resolved target address. It generates the instruction-memory fetch address, boots from a reset vector stored in instruction memory, and applies stall, jump and halt control. It also produces the pipeline flush pulse that kills the wrong-path instruction.

Parameters:
PC_WIDTH, 32, width of PC, target and instruction-memory address
INSTR_STEP, 1, PC increment per sequential fetch (word-addressed memory)
RESET_VECTOR_ADDR, 0, imem address holding the boot PC

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_data  in  PC_WIDTH  instruction memory read data; synchronous read, valid one cycle after imem_addr
jump  in  1  taken-branch request from branch decision logic (already qualified by valid)
jump_target  in  PC_WIDTH  resolved branch/jump destination
stall  in  1  hazard-unit stall; hold PC
halt  in  1  HLT instruction decoded; stop fetching
imem_addr  out  PC_WIDTH  fetch address to instruction memory
pc  out  PC_WIDTH  current PC register
fetch_valid  out  1  imem_data next cycle is a real instruction to latch into IF/ID
flush  out  1  kill the instruction currently in IF/ID (wrong path)

Behaviour:
- FSM states: BOOT, LOAD, RUN, HALTED. Encoding is free.
- rst_n=0 sampled at an edge: state<=BOOT, pc<=0. Outputs while in reset/BOOT: fetch_valid=0, flush=0, imem_addr=RESET_VECTOR_ADDR. Reset wins over every other input in every state, including mid-boot and HALTED.
- BOOT (1 cycle):
  - drives imem_addr=RESET_VECTOR_ADDR.
  - next state LOAD unconditionally; jump/stall/halt ignored.
- LOAD (1 cycle):
  - pc<=imem_data (boot PC); next state RUN.
  - imem_addr=RESET_VECTOR_ADDR, fetch_valid=0; jump/stall/halt ignored.
- RUN:
  - imem_addr=pc combinationally.
  - fetch_valid = ~stall & ~jump & ~halt.
  - Next-PC priority, highest first:
    - jump: pc<=jump_target; flush=1 combinationally in the same cycle. Jump overrides stall.
    - halt: pc held; next state HALTED.
    - stall: pc held.
    - else: pc<=pc+INSTR_STEP, modulo 2^PC_WIDTH. Wrap-around from all-ones to 0 is silent.
- jump and halt in the same cycle: jump taken; halt is on the wrong path, so stay in RUN.
- flush is 1 only in RUN with jump=1; it is never asserted in BOOT, LOAD or HALTED.
- HALTED:
  - pc held, fetch_valid=0, flush=0, imem_addr=pc.
  - all inputs ignored; exit only via reset.
- Latency: first valid fetch is at cycle 3 after reset release (BOOT, LOAD, then RUN presents the boot PC with fetch_valid=1).
- Jump latency: target is fetched in the cycle after jump is asserted.
- No combinational path from imem_data to any output.

Test Plan:
- Boot: mem[0]=0x0000_0040; release rst_n -> BOOT then LOAD; imem_addr=0 for 2 cycles; 3rd cycle pc=0x40, imem_addr=0x40, fetch_valid=1; next cycles pc=0x41, 0x42.
- Stall: in RUN at pc=0x50, stall=1 for 3 cycles -> pc stays 0x50, fetch_valid=0; after stall drops -> pc=0x51.
- Jump vs stall: pc=0x60, jump=1, stall=1, jump_target=0x100 -> flush=1 that cycle, fetch_valid=0; next cycle pc=0x100, flush=0.
- Halt, and jump+halt: halt=1 at pc=0x70 -> HALTED, pc stuck at 0x70 for 10 cycles despite jump/stall toggling. Separately, jump=1 with halt=1, jump_target=0x200 -> pc=0x200, stays in RUN.
- Wrap: boot vector 0xFFFF_FFFF -> next pc=0x0000_0000, no error.
- Reset mid-operation: rst_n=0 for 1 cycle during RUN, and again during LOAD -> both restart at BOOT. pc is reloaded from mem[0]; fetch_valid and flush stay 0 until RUN.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boots from a vector held in instruction memory,
// then steps, stalls, jumps and halts under control of the hazard and branch logic.
module pc_unit #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTR_STEP        = 1,
    parameter int RESET_VECTOR_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] imem_data,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                stall,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                flush
);

    localparam logic [PC_WIDTH-1:0] RV_ADDR = PC_WIDTH'(RESET_VECTOR_ADDR);
    localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(INSTR_STEP);

    typedef enum logic [1:0] {
        S_BOOT,
        S_LOAD,
        S_RUN,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr   = RV_ADDR;
        fetch_valid = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Boot PC arrives from the vector read issued during BOOT.
                pc_d    = imem_data;
                state_d = S_RUN;
            end
            S_RUN: begin
                imem_addr   = pc_q;
                fetch_valid = ~stall & ~jump & ~halt;
                if (jump) begin
                    // A same-cycle halt is on the wrong path, so it is dropped.
                    pc_d  = jump_target;
                    flush = 1'b1;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (!stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            S_HALTED: begin
                imem_addr = pc_q;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, stall, jump priority, halt, wrap and
// mid-operation reset, with a synchronous-read instruction memory model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_data;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        halt;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;

    logic [31:0] boot_vec;
    int          total = 0;
    int          bad   = 0;

    pc_unit #(
        .PC_WIDTH         (32),
        .INSTR_STEP       (1),
        .RESET_VECTOR_ADDR(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_data  (imem_data),
        .jump       (jump),
        .jump_target(jump_target),
        .stall      (stall),
        .halt       (halt),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: only address 0 holds the boot vector.
    always @(posedge clk)
        imem_data <= (imem_addr == 32'h0) ? boot_vec : (32'hDEAD_0000 | imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks all run-state outputs in one call; inputs are settled first.
    task automatic check_outs(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_addr, input logic e_fv,
                              input logic e_fl);
        #1;
        check({tag, ".pc"},          pc,                 e_pc);
        check({tag, ".imem_addr"},   imem_addr,          e_addr);
        check({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e_fv});
        check({tag, ".flush"},       {31'b0, flush},       {31'b0, e_fl});
    endtask

    task automatic set_in(input logic j, input logic [31:0] tgt, input logic s, input logic h);
        jump        = j;
        jump_target = tgt;
        stall       = s;
        halt        = h;
    endtask

    initial begin
        rst_n    = 1'b0;
        boot_vec = 32'h0000_0040;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset held, with control inputs asserted: must stay in BOOT.
        tick();
        tick();
        set_in(1'b1, 32'h1234, 1'b1, 1'b1);
        check_outs("rst", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Release: BOOT, then LOAD (inputs ignored), then RUN at the boot PC.
        rst_n = 1'b1;
        check_outs("boot", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_outs("load", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_outs("run0", 32'h40, 32'h40, 1'b1, 1'b0);
        tick();
        check_outs("run1", 32'h41, 32'h41, 1'b1, 1'b0);
        tick();
        check_outs("run2", 32'h42, 32'h42, 1'b1, 1'b0);

        // Jump to 0x50, then stall three cycles.
        set_in(1'b1, 32'h50, 1'b0, 1'b0);
        check_outs("j50", 32'h42, 32'h42, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_outs($sformatf("stall%0d", i), 32'h50, 32'h50, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_outs("unstall", 32'h50, 32'h50, 1'b1, 1'b0);
        tick();
        check_outs("post_stall", 32'h51, 32'h51, 1'b1, 1'b0);

        // Jump overrides stall.
        set_in(1'b1, 32'h60, 1'b0, 1'b0);
        #1;
        tick();
        set_in(1'b1, 32'h100, 1'b1, 1'b0);
        check_outs("jstall", 32'h60, 32'h60, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_outs("jstall_tgt", 32'h100, 32'h100, 1'b1, 1'b0);

        // Jump with halt: jump taken, stays in RUN.
        set_in(1'b1, 32'h200, 1'b0, 1'b1);
        check_outs("jhalt", 32'h100, 32'h100, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_outs("jhalt_tgt", 32'h200, 32'h200, 1'b1, 1'b0);
        tick();
        check_outs("jhalt_run", 32'h201, 32'h201, 1'b1, 1'b0);

        // Halt at 0x70; then ten cycles of toggling jump/stall are ignored.
        set_in(1'b1, 32'h70, 1'b0, 1'b0);
        #1;
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        check_outs("halt", 32'h70, 32'h70, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(i[0], 32'h300, i[1], 1'b0);
            check_outs($sformatf("halted%0d", i), 32'h70, 32'h70, 1'b0, 1'b0);
            tick();
        end

        // Reset out of HALTED with an all-ones boot vector: PC wraps to 0.
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        boot_vec = 32'hFFFF_FFFF;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outs("wrap_boot", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_outs("wrap_run", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        check_outs("wrap0", 32'h0, 32'h0, 1'b1, 1'b0);

        // One-cycle reset during RUN, then again during LOAD.
        boot_vec = 32'h0000_0080;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outs("rrun_boot", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h500, 1'b0, 1'b0);
        check_outs("rrun_load", 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outs("rload_boot", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_outs("rload_load", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        check_outs("rload_run", 32'h80, 32'h80, 1'b1, 1'b0);
        tick();
        check_outs("rload_run1", 32'h81, 32'h81, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
